ladybird_ifetch: RTL and testbench

- Instruction fetch stage for the ladybird RV32 core. Sits directly upstream of decode and produces the 32-bit instruction words that decode consumes.
- Issues word-aligned fetch requests to instruction memory and keeps responses in a small in-order buffer.
- Presents {pc, instruction} to decode over a valid/ready handshake.
- Handles redirects (branch, jump, trap) by flushing buffered and in-flight fetches.

---
 rtl/ladybird_ifetch_if.sv | 55 +++++
 rtl/ladybird_ifetch.sv | 185 ++++++++++++++++++
 tb/tb_ladybird_ifetch.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ladybird_ifetch_if.sv
// ladybird_ifetch_if: redirect, instruction-memory and decode-side signals of
// the ladybird fetch stage. The master modport is the fetch stage; the slave
// modport is its environment (core control, instruction memory, decode).
//
// Handshake rule for every valid/ready pair here: a transfer happens in each
// cycle where valid and ready are both high at the rising clock edge. A valid
// never depends on the ready of its own channel. The memory response channel
// has no ready: the fetch stage only requests when a buffer slot is reserved.
interface ladybird_ifetch_if;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_req_ready;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_resp_data;
    logic        i_mem_resp_error;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_fault;
    logic        i_inst_ready;

    modport master (
        input  i_redirect_valid,
        input  i_redirect_pc,
        output o_mem_req_valid,
        output o_mem_req_addr,
        input  i_mem_req_ready,
        input  i_mem_resp_valid,
        input  i_mem_resp_data,
        input  i_mem_resp_error,
        output o_inst_valid,
        output o_inst,
        output o_inst_pc,
        output o_inst_fault,
        input  i_inst_ready
    );

    modport slave (
        output i_redirect_valid,
        output i_redirect_pc,
        input  o_mem_req_valid,
        input  o_mem_req_addr,
        output i_mem_req_ready,
        output i_mem_resp_valid,
        output i_mem_resp_data,
        output i_mem_resp_error,
        input  o_inst_valid,
        input  o_inst,
        input  o_inst_pc,
        input  o_inst_fault,
        output i_inst_ready
    );
endinterface

// File: rtl/ladybird_ifetch.sv
// ladybird_ifetch: instruction fetch stage of the ladybird RV32 core.
// Issues word-aligned fetches, keeps in-order responses in a DEPTH-entry
// buffer and hands {pc, instruction} to decode. A redirect flushes the
// buffer and marks every unanswered request for discard.
//
// Optional build macro LADYBIRD_IFETCH_FAULT_NOP_EN: when defined, an
// erroring response is buffered as a NOP (ADDI x0,x0,0) with o_inst_fault
// set; when undefined the error bit is ignored and o_inst_fault is 0.
module ladybird_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst,
    ladybird_ifetch_if.master bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Fetch pointer and start-up gate.
    logic          req_en;
    logic [31:0]   fetch_pc;

    // In-flight accounting: outst counts every unanswered request, discard
    // counts how many of those belong to a flushed stream.
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;

    // pc of each unanswered request, in issue order.
    logic [31:0]   q_pc [DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;

    // Instruction buffer.
    logic [31:0]   b_pc   [DEPTH];
    logic [31:0]   b_inst [DEPTH];
    logic [AW-1:0] b_head;
    logic [AW-1:0] b_tail;
    logic [CW-1:0] occ;

    // Per-cycle control.
    logic          redirect;
    logic [CW:0]   credit_used;
    logic          req_valid;
    logic          req_fire;
    logic          resp;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [CW-1:0] outst_after;
    logic [31:0]   resp_inst;

    // Handshake qualifiers and credit check; a slot is reserved per request.
    always_comb begin
        redirect    = bus.i_redirect_valid;
        credit_used = {1'b0, occ} + {1'b0, outst};
        req_valid   = req_en && !redirect && (credit_used < {1'b0, DEPTH_C});
        req_fire    = req_valid && bus.i_mem_req_ready;
        resp        = bus.i_mem_resp_valid;
        resp_drop   = resp && (discard != '0);
        push        = resp && !resp_drop && !redirect;
        pop         = (occ != '0) && bus.i_inst_ready && !redirect;
        outst_after = outst + CW'(req_fire) - CW'(resp);
    end

`ifdef LADYBIRD_IFETCH_FAULT_NOP_EN
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic          resp_fault;
    logic          b_fault [DEPTH];

    // Faulted fetches carry a harmless NOP so decode only has to look at the flag.
    always_comb begin
        resp_fault = bus.i_mem_resp_error;
        resp_inst  = bus.i_mem_resp_error ? NOP : bus.i_mem_resp_data;
    end

    // Fault flag storage, indexed exactly like the main buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) b_fault[i] <= 1'b0;
        end else if (push) begin
            b_fault[b_tail] <= resp_fault;
        end
    end

    assign bus.o_inst_fault = (occ != '0) && b_fault[b_head];
`else
    logic unused_resp_error;

    // Data passes straight through; the error bit has no effect.
    always_comb begin
        resp_inst = bus.i_mem_resp_data;
    end

    assign unused_resp_error = bus.i_mem_resp_error;
    assign bus.o_inst_fault  = 1'b0;
`endif

    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_req_addr  = fetch_pc;
    assign bus.o_inst_valid    = (occ != '0);
    assign bus.o_inst          = (occ != '0) ? b_inst[b_head] : '0;
    assign bus.o_inst_pc       = (occ != '0) ? b_pc[b_head]   : '0;

    // Requests start one cycle after reset is released, never during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) req_en <= 1'b0;
        else     req_en <= 1'b1;
    end

    // Fetch pointer: jump to the aligned redirect target, else step on each request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= {bus.i_redirect_pc[31:2], 2'b00};
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Outstanding/discard counters; a redirect condemns everything still unanswered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst   <= '0;
            discard <= '0;
        end else begin
            outst <= outst_after;
            if (redirect) begin
                discard <= outst_after;
            end else if (resp_drop) begin
                discard <= discard - CW'(1);
            end
        end
    end

    // Request pc queue: one entry per unanswered request, popped by every response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_wr <= '0;
            q_rd <= '0;
            for (int i = 0; i < DEPTH; i++) q_pc[i] <= '0;
        end else begin
            if (req_fire) begin
                q_pc[q_wr] <= fetch_pc;
                q_wr       <= q_wr + AW'(1);
            end
            if (resp) begin
                q_rd <= q_rd + AW'(1);
            end
        end
    end

    // Instruction buffer: write live responses at the tail, pop to decode at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_head <= '0;
            b_tail <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                b_pc[i]   <= '0;
                b_inst[i] <= '0;
            end
        end else if (redirect) begin
            b_head <= '0;
            b_tail <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                b_pc[b_tail]   <= q_pc[q_rd];
                b_inst[b_tail] <= resp_inst;
                b_tail         <= b_tail + AW'(1);
            end
            if (pop) begin
                b_head <= b_head + AW'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_ladybird_ifetch.sv
// tb_ladybird_ifetch: randomized bench for ladybird_ifetch. The reference
// model is the architectural fetch stream: after reset or a redirect, decode
// must see pc = base, base+4, ... with the memory word of each pc, and the
// memory must see requests for exactly those addresses.
module tb_ladybird_ifetch;
    localparam logic [31:0] RST_PC = 32'h0000_1000;
    localparam int          DEPTH  = 2;

    logic clk;
    logic rst;

    ladybird_ifetch_if bus ();

    ladybird_ifetch #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counters and environment knobs.
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int lat         = 1;
    int mem_rdy_pct = 100;
    int dec_rdy_pct = 100;
    int resp_pct    = 100;
    bit err_en      = 1'b0;

    bit          redir_req = 1'b0;
    logic [31:0] redir_pc  = '0;
    bit          arm_coinc = 1'b0;
    logic [31:0] arm_pc    = '0;
    bit          coinc_hit = 1'b0;
    bit          prev_redirect = 1'b0;

    int redir_req_err  = 0;
    int post_redir_err = 0;
    int credit_err     = 0;

    // Memory model state and observations.
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] req_q[$];
    logic [64:0] obs_q[$];
    logic [64:0] exp_q[$];

    // Reference model: memory contents, error map and the expected stream.
    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic mem_err(logic [31:0] a);
        return err_en && (a[3:2] == 2'b01);
    endfunction

    function automatic logic [64:0] exp_entry(logic [31:0] pc);
        logic [31:0] w;
        logic        f;
        w = mem_word(pc);
        f = 1'b0;
`ifdef LADYBIRD_IFETCH_FAULT_NOP_EN
        if (mem_err(pc)) begin
            w = 32'h0000_0013;
            f = 1'b1;
        end
`endif
        return {pc, w, f};
    endfunction

    function automatic void build_stream(logic [31:0] base, int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_entry(base + 32'(4 * i)));
    endfunction

    // Driver/monitor: one clock cycle. Inputs change on the falling edge,
    // outputs are sampled 1 time unit later.
    task automatic step();
        bit          resp_now;
        bit          redirect;
        bit          fire;
        @(negedge clk);
        cyc++;
        bus.i_mem_req_ready = ($urandom_range(1, 100) <= mem_rdy_pct);
        bus.i_inst_ready    = ($urandom_range(1, 100) <= dec_rdy_pct);
        resp_now = (pend_addr.size() > 0) && ($urandom_range(1, 100) <= resp_pct);
        if (resp_now) resp_now = (pend_due[0] <= cyc);
        bus.i_mem_resp_valid = resp_now;
        if (resp_now) begin
            bus.i_mem_resp_data  = mem_word(pend_addr[0]);
            bus.i_mem_resp_error = mem_err(pend_addr[0]);
        end else begin
            bus.i_mem_resp_data  = $urandom;
            bus.i_mem_resp_error = 1'b0;
        end
        redirect = redir_req;
        if (arm_coinc && bus.o_inst_valid && resp_now && bus.i_inst_ready) begin
            redirect  = 1'b1;
            redir_pc  = arm_pc;
            arm_coinc = 1'b0;
            coinc_hit = 1'b1;
        end
        bus.i_redirect_valid = redirect;
        bus.i_redirect_pc    = redir_pc;
        #1;
        if (prev_redirect && bus.o_inst_valid) post_redir_err++;
        if (redirect && bus.o_mem_req_valid) redir_req_err++;
        fire = bus.o_mem_req_valid && bus.i_mem_req_ready;
        if (fire) begin
            if (pend_addr.size() >= DEPTH) credit_err++;
            pend_addr.push_back(bus.o_mem_req_addr);
            pend_due.push_back(cyc + lat);
            req_q.push_back(bus.o_mem_req_addr);
        end
        if (resp_now) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (bus.o_inst_valid && bus.i_inst_ready && !redirect)
            obs_q.push_back({bus.o_inst_pc, bus.o_inst, bus.o_inst_fault});
        if (redirect) begin
            obs_q.delete();
            req_q.delete();
        end
        prev_redirect = redirect;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redir_req = 1'b1;
        redir_pc  = pc;
        step();
        redir_req = 1'b0;
    endtask

    // Reset values, and first request one cycle after release.
    task automatic test_reset();
        rst = 1'b1;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        bus.i_mem_req_ready  = 1'b1;
        bus.i_mem_resp_valid = 1'b0;
        bus.i_mem_resp_data  = '0;
        bus.i_mem_resp_error = 1'b0;
        bus.i_inst_ready     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++; if (bus.o_mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", bus.o_mem_req_valid); end
        n_tests++; if (bus.o_mem_req_addr !== RST_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", bus.o_mem_req_addr, RST_PC); end
        n_tests++; if (bus.o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b expected 0", bus.o_inst_valid); end
        n_tests++; if (bus.o_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", bus.o_inst); end
        n_tests++; if (bus.o_inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 0", bus.o_inst_pc); end
        n_tests++; if (bus.o_inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_inst_fault: got %b expected 0", bus.o_inst_fault); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (bus.o_mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL release_req_valid: got %b expected 0", bus.o_mem_req_valid); end
        step();
        n_tests++; if (req_q.size() != 1 || bus.o_mem_req_addr !== RST_PC) begin n_fail++; $display("FAIL first_request: got %0d reqs addr %h expected 1 req addr %h", req_q.size(), bus.o_mem_req_addr, RST_PC); end
    endtask

    // Plain sequential fetch from the reset pc.
    task automatic test_stream();
        run(20);
        build_stream(RST_PC, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL stream_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < req_q.size(); i++) begin
            n_tests++; if (req_q[i] !== RST_PC + 32'(4 * i)) begin n_fail++; $display("FAIL stream_req[%0d]: got %h expected %h", i, req_q[i], RST_PC + 32'(4 * i)); end
        end
    endtask

    // Decode stalled: exactly DEPTH requests, then resume without loss.
    task automatic test_backpressure();
        dec_rdy_pct = 0;
        redirect_to(RST_PC);
        run(12);
        n_tests++; if (req_q.size() != DEPTH) begin n_fail++; $display("FAIL bp_req_count: got %0d expected %0d", req_q.size(), DEPTH); end
        n_tests++; if (req_q.size() < 2 || req_q[0] !== 32'h1000 || req_q[1] !== 32'h1004) begin n_fail++; $display("FAIL bp_req_addrs: got %0d reqs, expected 1000,1004", req_q.size()); end
        n_tests++; if (bus.o_mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_held: got %b expected 0", bus.o_mem_req_valid); end
        n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL bp_no_pop: got %0d insts expected 0", obs_q.size()); end
        dec_rdy_pct = 100;
        run(24);
        build_stream(RST_PC, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL bp_resume_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 0; i < req_q.size(); i++) begin
            n_tests++; if (req_q[i] !== RST_PC + 32'(4 * i)) begin n_fail++; $display("FAIL bp_req[%0d]: got %h expected %h", i, req_q[i], RST_PC + 32'(4 * i)); end
        end
    endtask

    // Redirect with two requests in flight: stale responses must vanish.
    task automatic test_redirect_outstanding();
        lat = 6;
        for (int k = 0; k < 40 && pend_addr.size() != 2; k++) step();
        n_tests++; if (pend_addr.size() != 2) begin n_fail++; $display("FAIL ro_setup: got %0d in flight expected 2", pend_addr.size()); end
        redirect_to(32'h0000_2003);
        lat = 2;
        run(40);
        n_tests++; if (req_q.size() == 0 || req_q[0] !== 32'h0000_2000) begin n_fail++; $display("FAIL ro_first_req: got %0d reqs expected first 00002000", req_q.size()); end
        build_stream(32'h0000_2000, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL ro_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ro_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
        n_tests++; if (redir_req_err != 0) begin n_fail++; $display("FAIL ro_req_in_redirect: got %0d expected 0", redir_req_err); end
    endtask

    // Redirect in the same cycle as a response and a decode pop.
    task automatic test_redirect_coincident();
        lat = 1;
        coinc_hit = 1'b0;
        arm_pc    = 32'h0000_3000;
        arm_coinc = 1'b1;
        for (int k = 0; k < 40 && !coinc_hit; k++) step();
        arm_coinc = 1'b0;
        n_tests++; if (!coinc_hit) begin n_fail++; $display("FAIL co_setup: got no coincident cycle expected one within 40 cycles"); end
        n_tests++; if (redir_req_err != 0) begin n_fail++; $display("FAIL co_req_in_redirect: got %0d expected 0", redir_req_err); end
        step();
        n_tests++; if (obs_q.size() != 0 || post_redir_err != 0) begin n_fail++; $display("FAIL co_buffer_empty: got %0d pops, %0d valid-after-redirect expected 0,0", obs_q.size(), post_redir_err); end
        run(20);
        build_stream(32'h0000_3000, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL co_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL co_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // Address wrap at the top of the address space.
    task automatic test_wrap();
        redirect_to(32'hFFFF_FFFA);
        run(20);
        n_tests++; if (req_q.size() < 3 || req_q[0] !== 32'hFFFF_FFF8 || req_q[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_reqs: got %0d reqs expected FFFFFFF8,FFFFFFFC,00000000..", req_q.size()); end
        build_stream(32'hFFFF_FFF8, obs_q.size());
        n_tests++; if (obs_q.size() < 4) begin n_fail++; $display("FAIL wrap_progress: got %0d insts expected >= 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // Access fault on the word at 0x1004.
    task automatic test_fault();
        logic [64:0] want;
        err_en = 1'b1;
        redirect_to(RST_PC);
        run(20);
`ifdef LADYBIRD_IFETCH_FAULT_NOP_EN
        want = {32'h0000_1004, 32'h0000_0013, 1'b1};
`else
        want = {32'h0000_1004, mem_word(32'h0000_1004), 1'b0};
`endif
        n_tests++; if (obs_q.size() < 2 || obs_q[1] !== want) begin n_fail++; $display("FAIL fault_entry: got %0d insts expected entry %h (pc,inst,fault)", obs_q.size(), want); end
        build_stream(RST_PC, obs_q.size());
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL fault_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
        err_en = 1'b0;
    endtask

    // Three consecutive redirects: discards accumulate, last target wins.
    task automatic test_back_to_back();
        lat = 3;
        run(6);
        redirect_to(32'h0000_4000);
        redirect_to(32'h0000_5000);
        redirect_to(32'h0000_6006);
        run(40);
        n_tests++; if (req_q.size() == 0 || req_q[0] !== 32'h0000_6004) begin n_fail++; $display("FAIL b2b_first_req: got %0d reqs expected first 00006004", req_q.size()); end
        build_stream(32'h0000_6004, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL b2b_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
        n_tests++; if (redir_req_err != 0 || post_redir_err != 0) begin n_fail++; $display("FAIL b2b_redirect_rules: got %0d,%0d expected 0,0", redir_req_err, post_redir_err); end
    endtask

    // Random ready/latency/response timing with random redirect targets.
    task automatic test_random();
        logic [31:0] base;
        for (int r = 0; r < 8; r++) begin
            mem_rdy_pct = $urandom_range(30, 100);
            dec_rdy_pct = $urandom_range(20, 100);
            resp_pct    = $urandom_range(30, 100);
            lat         = $urandom_range(1, 4);
            base        = $urandom;
            redirect_to(base);
            base[1:0] = 2'b00;
            run($urandom_range(30, 70));
            build_stream(base, obs_q.size());
            for (int i = 0; i < obs_q.size(); i++) begin
                n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd%0d_stream[%0d]: got %h expected %h (pc,inst,fault)", r, i, obs_q[i], exp_q[i]); end
            end
            for (int i = 0; i < req_q.size(); i++) begin
                n_tests++; if (req_q[i] !== base + 32'(4 * i)) begin n_fail++; $display("FAIL rnd%0d_req[%0d]: got %h expected %h", r, i, req_q[i], base + 32'(4 * i)); end
            end
        end
        mem_rdy_pct = 100;
        dec_rdy_pct = 100;
        resp_pct    = 100;
        lat         = 1;
        n_tests++; if (credit_err != 0) begin n_fail++; $display("FAIL rnd_credit: got %0d over-credit requests expected 0", credit_err); end
        n_tests++; if (redir_req_err != 0 || post_redir_err != 0) begin n_fail++; $display("FAIL rnd_redirect_rules: got %0d,%0d expected 0,0", redir_req_err, post_redir_err); end
    endtask

    // Asynchronous reset in the middle of traffic.
    task automatic test_mid_reset();
        run(5);
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if (bus.o_mem_req_valid !== 1'b0 || bus.o_inst_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valids: got req=%b inst=%b expected 0,0", bus.o_mem_req_valid, bus.o_inst_valid); end
        n_tests++; if (bus.o_mem_req_addr !== RST_PC) begin n_fail++; $display("FAIL midrst_addr: got %h expected %h", bus.o_mem_req_addr, RST_PC); end
        pend_addr.delete();
        pend_due.delete();
        obs_q.delete();
        req_q.delete();
        prev_redirect = 1'b0;
        bus.i_mem_resp_valid = 1'b0;
        bus.i_redirect_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(20);
        build_stream(RST_PC, obs_q.size());
        n_tests++; if (obs_q.size() < 5) begin n_fail++; $display("FAIL midrst_progress: got %0d insts expected >= 5", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL midrst_stream[%0d]: got %h expected %h (pc,inst,fault)", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // Test sequence and final report.
    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_wrap();
        test_fault();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
